// File: rtl/sprite_collision_mixer.sv
// Pixel compositor for target/projectile/player/background layers with
// per-target alive mask and a kill-event FIFO drained over valid/ready.
module sprite_collision_mixer #(
    parameter int N_TGT     = 5,
    parameter int N_PRJ     = 8,
    parameter int PIX_W     = 4,
    parameter int HIT_DEPTH = 4
) (
    input  logic                                   vga_clk_i,
    input  logic                                   vga_rst_i,
    input  logic                                   video_on_i,
    input  logic [PIX_W-1:0]                       bg_pix_i,
    input  logic [N_TGT-1:0]                       tgt_active_i,
    input  logic [PIX_W-1:0]                       tgt_pix_i,
    input  logic [N_PRJ-1:0]                       prj_active_i,
    input  logic [PIX_W-1:0]                       prj_pix_i,
    input  logic                                   plyr_active_i,
    input  logic [PIX_W-1:0]                       plyr_pix_i,
    input  logic                                   revive_i,
    output logic [PIX_W-1:0]                       vga_r,
    output logic [PIX_W-1:0]                       vga_g,
    output logic [PIX_W-1:0]                       vga_b,
    output logic [N_TGT-1:0]                       tgt_alive_o,
    output logic [$clog2(N_TGT+1)-1:0]             alive_cnt_o,
    output logic                                   all_dead_o,
    output logic                                   hit_valid_o,
    output logic [(N_TGT>1?$clog2(N_TGT):1)-1:0]   hit_idx_o,
    input  logic                                   hit_ready_i,
    output logic                                   overflow_o
);
    localparam int IDX_W  = (N_TGT > 1) ? $clog2(N_TGT) : 1;
    localparam int CNT_W  = $clog2(N_TGT + 1);
    localparam int PTR_W  = $clog2(HIT_DEPTH);
    localparam int FCNT_W = PTR_W + 1;

    logic [N_TGT-1:0]  alive_q, alive_d, live, kill_oh;
    logic [CNT_W-1:0]  cnt_q;
    logic [PIX_W-1:0]  pix_q, pix_d;
    logic [IDX_W-1:0]  kill_idx;
    logic [IDX_W-1:0]  mem [HIT_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [FCNT_W-1:0] fcnt_q;
    logic              ovf_q, hit, full, pop, do_push;

    function automatic logic [CNT_W-1:0] popcnt(input logic [N_TGT-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < N_TGT; i++) c = c + CNT_W'(v[i]);
        return c;
    endfunction

    assign live    = tgt_active_i & alive_q;
    assign hit     = video_on_i & (|prj_active_i) & (|live);
    // Isolate the lowest live target; only that one dies this pixel.
    assign kill_oh = hit ? (live & (~live + N_TGT'(1))) : '0;
    assign alive_d = alive_q & ~kill_oh;

    always_comb begin
        kill_idx = '0;
        for (int i = N_TGT - 1; i >= 0; i--) begin
            if (live[i]) kill_idx = IDX_W'(i);
        end
    end

    always_comb begin
        pix_d = bg_pix_i;
        if (!video_on_i)         pix_d = '0;
        else if (|live)          pix_d = tgt_pix_i;
        else if (|prj_active_i)  pix_d = prj_pix_i;
        else if (plyr_active_i)  pix_d = plyr_pix_i;
    end

    assign full    = (fcnt_q == FCNT_W'(HIT_DEPTH));
    assign pop     = (fcnt_q != '0) & hit_ready_i;
    assign do_push = hit & (~full | pop);

    always_ff @(posedge vga_clk_i or negedge vga_rst_i) begin
        if (!vga_rst_i) begin
            alive_q <= '1;
            cnt_q   <= CNT_W'(N_TGT);
            pix_q   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            fcnt_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            pix_q <= pix_d;
            if (revive_i) begin
                alive_q <= '1;
                cnt_q   <= CNT_W'(N_TGT);
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                fcnt_q  <= '0;
                ovf_q   <= 1'b0;
            end else begin
                alive_q <= alive_d;
                cnt_q   <= popcnt(alive_d);
                if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
                fcnt_q <= fcnt_q + FCNT_W'(do_push) - FCNT_W'(pop);
                if (hit && full && !pop) ovf_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge vga_clk_i) begin
        if (do_push && !revive_i) mem[wr_ptr] <= kill_idx;
    end

    assign vga_r       = pix_q;
    assign vga_g       = pix_q;
    assign vga_b       = pix_q;
    assign tgt_alive_o = alive_q;
    assign alive_cnt_o = cnt_q;
    assign all_dead_o  = (cnt_q == '0);
    assign hit_valid_o = (fcnt_q != '0);
    assign hit_idx_o   = hit_valid_o ? mem[rd_ptr] : '0;
    assign overflow_o  = ovf_q;
endmodule

// File: tb/tb_sprite_collision_mixer.sv
// Bench for sprite_collision_mixer: vector table, corner sequences and a
// randomized run against a queue-based reference model.
module tb_sprite_collision_mixer;
    localparam int N_TGT = 5;
    localparam int N_PRJ = 8;
    localparam int PIX_W = 4;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic             von, plyr, revive, ready;
    logic [PIX_W-1:0] bg, tgt_pix, prj_pix, plyr_pix;
    logic [N_TGT-1:0] tgt_act;
    logic [N_PRJ-1:0] prj_act;

    logic [PIX_W-1:0] vga_r, vga_g, vga_b;
    logic [N_TGT-1:0] tgt_alive;
    logic [2:0]       alive_cnt;
    logic             all_dead, hit_valid, overflow;
    logic [2:0]       hit_idx;

    sprite_collision_mixer #(
        .N_TGT(N_TGT), .N_PRJ(N_PRJ), .PIX_W(PIX_W), .HIT_DEPTH(DEPTH)
    ) dut (
        .vga_clk_i(clk), .vga_rst_i(rst_n), .video_on_i(von),
        .bg_pix_i(bg), .tgt_active_i(tgt_act), .tgt_pix_i(tgt_pix),
        .prj_active_i(prj_act), .prj_pix_i(prj_pix),
        .plyr_active_i(plyr), .plyr_pix_i(plyr_pix), .revive_i(revive),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .tgt_alive_o(tgt_alive), .alive_cnt_o(alive_cnt),
        .all_dead_o(all_dead), .hit_valid_o(hit_valid),
        .hit_idx_o(hit_idx), .hit_ready_i(ready), .overflow_o(overflow)
    );

    int total = 0;
    int bad = 0;

    bit m_alive[N_TGT];
    int m_q[$];
    bit m_ovf;
    int m_pix;

    typedef struct {
        logic       von;
        logic [4:0] tgt;
        logic [7:0] prj;
        logic       plyr;
        logic       rdy;
        int         e_pix;
        int         e_alive;
        int         e_cnt;
        int         e_valid;
        int         e_idx;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N_TGT; i++) m_alive[i] = 1'b1;
        m_q.delete();
        m_ovf = 1'b0;
        m_pix = 0;
    endtask

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < N_TGT; i++) c += int'(m_alive[i]);
        return c;
    endfunction

    task automatic model_step();
        int k = -1;
        bit hit, pop;
        for (int i = 0; i < N_TGT; i++)
            if (tgt_act[i] && m_alive[i] && k < 0) k = i;
        if (!von)              m_pix = 0;
        else if (k >= 0)       m_pix = int'(tgt_pix);
        else if (prj_act != 0) m_pix = int'(prj_pix);
        else if (plyr)         m_pix = int'(plyr_pix);
        else                   m_pix = int'(bg);
        hit = von && (prj_act != 0) && (k >= 0);
        pop = (m_q.size() > 0) && ready;
        if (revive) begin
            for (int i = 0; i < N_TGT; i++) m_alive[i] = 1'b1;
            m_q.delete();
            m_ovf = 1'b0;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (hit) begin
                m_alive[k] = 1'b0;
                if (m_q.size() < DEPTH) m_q.push_back(k);
                else m_ovf = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        logic [N_TGT-1:0] a;
        for (int i = 0; i < N_TGT; i++) a[i] = m_alive[i];
        chk("vga_r", 32'(vga_r), 32'(m_pix));
        chk("vga_g", 32'(vga_g), 32'(m_pix));
        chk("vga_b", 32'(vga_b), 32'(m_pix));
        chk("alive", 32'(tgt_alive), 32'(a));
        chk("cnt", 32'(alive_cnt), 32'(m_count()));
        chk("all_dead", 32'(all_dead), 32'(m_count() == 0));
        chk("valid", 32'(hit_valid), 32'(m_q.size() > 0));
        chk("idx", 32'(hit_idx), (m_q.size() > 0) ? 32'(m_q[0]) : 32'd0);
        chk("ovf", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle();
        von = 1'b1; tgt_act = '0; prj_act = '0; plyr = 1'b0;
        revive = 1'b0; ready = 1'b0;
        bg = 4'h3; tgt_pix = 4'hF; prj_pix = 4'hA; plyr_pix = 4'h6;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        tbl[0] = '{1'b1, 5'b00000, 8'h00, 1'b0, 1'b0, 3, 'h1F, 5, 0, 0};
        tbl[1] = '{1'b1, 5'b00100, 8'h01, 1'b0, 1'b0, 15, 'h1B, 4, 1, 2};
        tbl[2] = '{1'b1, 5'b00100, 8'h01, 1'b0, 1'b0, 10, 'h1B, 4, 1, 2};
        tbl[3] = '{1'b1, 5'b01010, 8'h01, 1'b0, 1'b1, 15, 'h19, 3, 1, 1};
        tbl[4] = '{1'b1, 5'b01010, 8'h01, 1'b0, 1'b1, 15, 'h11, 2, 1, 3};
        tbl[5] = '{1'b1, 5'b00000, 8'h00, 1'b1, 1'b1, 6, 'h11, 2, 0, 0};
        tbl[6] = '{1'b0, 5'b10001, 8'h01, 1'b0, 1'b0, 0, 'h11, 2, 0, 0};
        tbl[7] = '{1'b1, 5'b00010, 8'h00, 1'b1, 1'b0, 6, 'h11, 2, 0, 0};

        idle();
        #12;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        for (int r = 0; r < 8; r++) begin
            von = tbl[r].von; tgt_act = tbl[r].tgt; prj_act = tbl[r].prj;
            plyr = tbl[r].plyr; ready = tbl[r].rdy;
            step();
            chk($sformatf("tbl%0d_pix", r), 32'(vga_r), tbl[r].e_pix);
            chk($sformatf("tbl%0d_alive", r), 32'(tgt_alive), tbl[r].e_alive);
            chk($sformatf("tbl%0d_cnt", r), 32'(alive_cnt), tbl[r].e_cnt);
            chk($sformatf("tbl%0d_valid", r), 32'(hit_valid), tbl[r].e_valid);
            chk($sformatf("tbl%0d_idx", r), 32'(hit_idx), tbl[r].e_idx);
        end

        // Overflow: five kills into a four-deep queue with no consumer.
        idle();
        do_reset();
        for (int k = 0; k < N_TGT; k++) begin
            tgt_act = N_TGT'(1 << k); prj_act = 8'h01;
            step();
            chk("t4_dead", 32'(all_dead), 32'(k == N_TGT - 1));
            chk("t4_ovf", 32'(overflow), 32'(k == N_TGT - 1));
        end
        chk("t4_cnt", 32'(alive_cnt), 0);
        idle();
        ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk("t4_head", 32'(hit_idx), i);
            step();
        end
        chk("t4_drained", 32'(hit_valid), 0);

        // Revive, refill, then revive racing a kill.
        idle();
        revive = 1'b1;
        step();
        chk("t5_alive", 32'(tgt_alive), 'h1F);
        chk("t5_ovf", 32'(overflow), 0);
        idle();
        for (int k = 0; k < DEPTH; k++) begin
            tgt_act = N_TGT'(1 << k); prj_act = 8'h01;
            step();
        end
        chk("t5_full", 32'(hit_valid), 1);
        tgt_act = 5'b10000; prj_act = 8'h01; revive = 1'b1;
        step();
        chk("t5_rev_alive", 32'(tgt_alive), 'h1F);
        chk("t5_rev_valid", 32'(hit_valid), 0);
        chk("t5_rev_ovf", 32'(overflow), 0);
        chk("t5_rev_pix", 32'(vga_r), 15);

        // Async reset in the middle of a kill cycle.
        idle();
        tgt_act = 5'b00001; prj_act = 8'h01;
        step();
        chk("t6_pre_alive", 32'(tgt_alive), 'h1E);
        tgt_act = 5'b00010;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_alive", 32'(tgt_alive), 'h1F);
        chk("t6_rst_pix", 32'(vga_r), 0);
        chk("t6_rst_cnt", 32'(alive_cnt), 5);
        chk("t6_rst_valid", 32'(hit_valid), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        idle();
        for (int n = 0; n < 400; n++) begin
            von      = ($urandom_range(0, 9) != 0);
            tgt_act  = N_TGT'($urandom & $urandom);
            prj_act  = ($urandom_range(0, 2) == 0) ?
                       N_PRJ'(1 << $urandom_range(0, 7)) : '0;
            plyr     = 1'($urandom_range(0, 1));
            bg       = PIX_W'($urandom);
            tgt_pix  = PIX_W'($urandom);
            prj_pix  = PIX_W'($urandom);
            plyr_pix = PIX_W'($urandom);
            ready    = ($urandom_range(0, 2) != 0);
            revive   = ($urandom_range(0, 39) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
